mem_responder: RTL and testbench

MEM_RESPONDER -- requirements
Module: mem_responder

---
 rtl/mem_responder_pkg.sv | 31 +++
 rtl/mem_responder_if.sv | 36 +++
 rtl/bus_timer.sv | 43 ++++
 rtl/mem_responder.sv | 120 ++++++++++++
 tb/tb_mem_responder.sv | 287 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/mem_responder_pkg.sv
// Shared types and constants for the CPU-to-Wishbone memory responder.
package mem_responder_pkg;

   localparam int unsigned ADDR_W = 32;
   localparam int unsigned DATA_W = 32;
   localparam int unsigned SEL_W  = 4;
   localparam int unsigned TMR_W  = 8;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      BUS  = 2'd1,
      RESP = 2'd2
   } state_e;

   // Read data returned to the CPU when the slave never answers.
   localparam logic [DATA_W-1:0] ERR_DATA = 32'hBAD0_BAD0;
   localparam logic [SEL_W-1:0]  SEL_ALL  = 4'hF;

   // Request captured from the CPU and presented on the Wishbone bus.
   typedef struct packed {
      logic              we;
      logic [ADDR_W-1:0] adr;
      logic [DATA_W-1:0] dat;
   } wb_req_t;

   // Wishbone addresses are word granular; drop the byte offset.
   function automatic logic [ADDR_W-1:0] word_align(input logic [ADDR_W-1:0] a);
      return {a[ADDR_W-1:2], 2'b00};
   endfunction

endpackage

// File: rtl/mem_responder_if.sv
// CPU request/response and Wishbone-classic signals of the responder.
// The slave modport is the responder's view; master is the environment
// (CPU plus Wishbone slave) that drives the requests and bus responses.
interface mem_responder_if;
   import mem_responder_pkg::*;

   logic              read;
   logic              write;
   logic [ADDR_W-1:0] address;
   logic [DATA_W-1:0] data;
   logic              ack;
   logic [DATA_W-1:0] dataOut;
   logic              bus_err;

   logic              wb_cyc_o;
   logic              wb_stb_o;
   logic              wb_we_o;
   logic [ADDR_W-1:0] wb_adr_o;
   logic [DATA_W-1:0] wb_dat_o;
   logic [SEL_W-1:0]  wb_sel_o;
   logic [DATA_W-1:0] wb_dat_i;
   logic              wb_ack_i;

   modport slave (
      input  read, write, address, data, wb_dat_i, wb_ack_i,
      output ack, dataOut, bus_err,
      output wb_cyc_o, wb_stb_o, wb_we_o, wb_adr_o, wb_dat_o, wb_sel_o
   );

   modport master (
      output read, write, address, data, wb_dat_i, wb_ack_i,
      input  ack, dataOut, bus_err,
      input  wb_cyc_o, wb_stb_o, wb_we_o, wb_adr_o, wb_dat_o, wb_sel_o
   );

endinterface

// File: rtl/bus_timer.sv
// Counts bus cycles spent waiting for a slave ack; expired_o is registered
// and rises in the cycle whose count equals TIMEOUT_CYCLES-1.
module bus_timer
   import mem_responder_pkg::*;
#(
   parameter logic [TMR_W-1:0] TIMEOUT_CYCLES = 8'd255
) (
   input  logic clk,
   input  logic rst,
   input  logic clear_i,
   input  logic enable_i,
   output logic expired_o
);

   localparam logic [TMR_W-1:0] LAST = TIMEOUT_CYCLES - TMR_W'(1);

   logic [TMR_W-1:0] count_q, count_d;
   logic             expired_q;

   // Next count: clear wins over enable.
   always_comb begin
      count_d = count_q;
      if (clear_i) begin
         count_d = '0;
      end else if (enable_i) begin
         count_d = count_q + TMR_W'(1);
      end
   end

   // Count register and look-ahead expiry flag.
   always_ff @(posedge clk) begin
      if (rst) begin
         count_q   <= '0;
         expired_q <= (LAST == TMR_W'(0));
      end else begin
         count_q   <= count_d;
         expired_q <= (count_d == LAST);
      end
   end

   assign expired_o = expired_q;

endmodule

// File: rtl/mem_responder.sv
// Turns a level CPU read/write request into one Wishbone-classic cycle,
// with a bounded wait for the slave and a one-cycle ack back to the CPU.
module mem_responder
   import mem_responder_pkg::*;
#(
   parameter logic [TMR_W-1:0] TIMEOUT_CYCLES = 8'd255
) (
   input  logic            clk,
   input  logic            rst,
   mem_responder_if.slave  mif
);

   state_e            state_q, state_d;
   wb_req_t           req_q, req_d;
   logic              cyc_q, cyc_d;
   logic [SEL_W-1:0]  sel_q, sel_d;
   logic              ack_q, ack_d;
   logic [DATA_W-1:0] rdata_q, rdata_d;
   logic              err_q, err_d;
   logic              timer_clr_c;
   logic              timer_en_c;
   logic              timer_exp;

   bus_timer #(
      .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
   ) u_bus_timer (
      .clk       (clk),
      .rst       (rst),
      .clear_i   (timer_clr_c),
      .enable_i  (timer_en_c),
      .expired_o (timer_exp)
   );

   // Next-state and registered-output logic; ack beats timeout in BUS.
   always_comb begin
      state_d     = state_q;
      req_d       = req_q;
      cyc_d       = cyc_q;
      sel_d       = sel_q;
      ack_d       = 1'b0;
      rdata_d     = rdata_q;
      err_d       = err_q;
      timer_clr_c = 1'b0;
      timer_en_c  = 1'b0;

      unique case (state_q)
         IDLE: begin
            if (mif.read | mif.write) begin
               req_d.we    = mif.write;
               req_d.adr   = word_align(mif.address);
               req_d.dat   = mif.data;
               sel_d       = SEL_ALL;
               cyc_d       = 1'b1;
               err_d       = 1'b0;
               timer_clr_c = 1'b1;
               state_d     = BUS;
            end
         end
         BUS: begin
            if (mif.wb_ack_i) begin
               if (!req_q.we) begin
                  rdata_d = mif.wb_dat_i;
               end
               cyc_d   = 1'b0;
               ack_d   = 1'b1;
               state_d = RESP;
            end else if (timer_exp) begin
               if (!req_q.we) begin
                  rdata_d = ERR_DATA;
               end
               err_d   = 1'b1;
               cyc_d   = 1'b0;
               ack_d   = 1'b1;
               state_d = RESP;
            end else begin
               timer_en_c = 1'b1;
            end
         end
         RESP: begin
            state_d = IDLE;
         end
         default: begin
            cyc_d   = 1'b0;
            state_d = IDLE;
         end
      endcase
   end

   // State and output registers.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
         req_q   <= '0;
         cyc_q   <= 1'b0;
         sel_q   <= '0;
         ack_q   <= 1'b0;
         rdata_q <= '0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         req_q   <= req_d;
         cyc_q   <= cyc_d;
         sel_q   <= sel_d;
         ack_q   <= ack_d;
         rdata_q <= rdata_d;
         err_q   <= err_d;
      end
   end

   assign mif.ack      = ack_q;
   assign mif.dataOut  = rdata_q;
   assign mif.bus_err  = err_q;
   assign mif.wb_cyc_o = cyc_q;
   assign mif.wb_stb_o = cyc_q;
   assign mif.wb_we_o  = req_q.we;
   assign mif.wb_adr_o = req_q.adr;
   assign mif.wb_dat_o = req_q.dat;
   assign mif.wb_sel_o = sel_q;

endmodule

// File: tb/tb_mem_responder.sv
// Scenario bench for mem_responder; responses are checked by a scoreboard.
module tb_mem_responder;

   logic clk;
   logic rst;
   int   vectors;
   int   miscompares;

   typedef struct packed {
      logic [31:0] data;
      logic        err;
   } exp_t;

   exp_t exp_q[$];

   mem_responder_if mif();

   mem_responder #(
      .TIMEOUT_CYCLES (8'd4)
   ) dut (
      .clk (clk),
      .rst (rst),
      .mif (mif.slave)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic tick();
      @(negedge clk);
   endtask

   // Scoreboard: every CPU ack pops one expected response.
   always @(negedge clk) begin
      if (!rst && mif.ack) begin
         vectors++;
         if (exp_q.size() == 0) begin
            miscompares++;
            $display("FAIL unexpected_ack: got ack=1 dataOut=%h, required no ack", mif.dataOut);
         end else begin
            exp_t e;
            e = exp_q.pop_front();
            if ({mif.dataOut, mif.bus_err} !== {e.data, e.err}) begin
               miscompares++;
               $display("FAIL resp: got dataOut=%h bus_err=%b, required %h %b",
                        mif.dataOut, mif.bus_err, e.data, e.err);
            end
         end
      end
   end

   task automatic test_reset();
      rst = 1'b1;
      repeat (3) tick();
      vectors++;
      if ({mif.ack, mif.wb_cyc_o, mif.wb_stb_o, mif.wb_we_o, mif.bus_err} !== 5'b0) begin
         miscompares++;
         $display("FAIL reset_ctrl: got %b required 00000",
                  {mif.ack, mif.wb_cyc_o, mif.wb_stb_o, mif.wb_we_o, mif.bus_err});
      end
      vectors++;
      if ({mif.wb_adr_o, mif.wb_dat_o, mif.dataOut, mif.wb_sel_o} !== 100'b0) begin
         miscompares++;
         $display("FAIL reset_data: got adr=%h dat=%h dataOut=%h sel=%h required all 0",
                  mif.wb_adr_o, mif.wb_dat_o, mif.dataOut, mif.wb_sel_o);
      end
      rst = 1'b0;
      tick();
      vectors++;
      if ({mif.ack, mif.wb_cyc_o} !== 2'b00) begin
         miscompares++;
         $display("FAIL idle_after_reset: got ack/cyc=%b required 00", {mif.ack, mif.wb_cyc_o});
      end
   endtask

   task automatic test_read_zero_wait();
      mif.read = 1'b1; mif.address = 32'h0000_1006;
      exp_q.push_back('{data: 32'hCAFE_F00D, err: 1'b0});
      tick();
      vectors++;
      if ({mif.wb_cyc_o, mif.wb_stb_o, mif.wb_we_o, mif.wb_sel_o} !== 7'b110_1111) begin
         miscompares++;
         $display("FAIL rd_req_ctrl: got cyc/stb/we/sel=%b required 1101111",
                  {mif.wb_cyc_o, mif.wb_stb_o, mif.wb_we_o, mif.wb_sel_o});
      end
      vectors++;
      if (mif.wb_adr_o !== 32'h0000_1004) begin
         miscompares++;
         $display("FAIL rd_adr: got %h required 00001004", mif.wb_adr_o);
      end
      mif.wb_ack_i = 1'b1; mif.wb_dat_i = 32'hCAFE_F00D;
      tick();
      vectors++;
      if ({mif.ack, mif.wb_cyc_o, mif.wb_stb_o} !== 3'b100) begin
         miscompares++;
         $display("FAIL rd_ack: got ack/cyc/stb=%b required 100", {mif.ack, mif.wb_cyc_o, mif.wb_stb_o});
      end
      mif.read = 1'b0; mif.wb_ack_i = 1'b0; mif.wb_dat_i = 32'h0;
      tick();
      vectors++;
      if ({mif.ack, mif.dataOut} !== {1'b0, 32'hCAFE_F00D}) begin
         miscompares++;
         $display("FAIL rd_hold: got ack=%b dataOut=%h required 0 cafef00d", mif.ack, mif.dataOut);
      end
   endtask

   task automatic test_write_wait();
      mif.write = 1'b1; mif.data = 32'h1234_5678; mif.address = 32'h0000_2000;
      exp_q.push_back('{data: 32'hCAFE_F00D, err: 1'b0});
      tick();
      mif.data = 32'hFFFF_0000; mif.address = 32'h0000_3333;
      for (int i = 0; i < 4; i++) begin
         vectors++;
         if ({mif.wb_cyc_o, mif.wb_stb_o, mif.wb_we_o, mif.wb_dat_o, mif.wb_adr_o}
             !== {3'b111, 32'h1234_5678, 32'h0000_2000}) begin
            miscompares++;
            $display("FAIL wr_bus_cycle%0d: got cyc/stb/we=%b dat=%h adr=%h required 111 12345678 00002000",
                     i, {mif.wb_cyc_o, mif.wb_stb_o, mif.wb_we_o}, mif.wb_dat_o, mif.wb_adr_o);
         end
         mif.wb_ack_i = (i == 3);
         mif.wb_dat_i = 32'h0BAD_F00D;
         tick();
      end
      vectors++;
      if ({mif.ack, mif.wb_cyc_o} !== 2'b10) begin
         miscompares++;
         $display("FAIL wr_ack: got ack/cyc=%b required 10", {mif.ack, mif.wb_cyc_o});
      end
      mif.write = 1'b0; mif.wb_ack_i = 1'b0;
      tick();
   endtask

   task automatic test_timeout();
      mif.read = 1'b1; mif.address = 32'h0000_4000;
      exp_q.push_back('{data: 32'hBAD0_BAD0, err: 1'b1});
      tick();
      for (int i = 0; i < 4; i++) begin
         vectors++;
         if (mif.wb_cyc_o !== 1'b1) begin
            miscompares++;
            $display("FAIL to_cyc%0d: got %b required 1", i, mif.wb_cyc_o);
         end
         tick();
      end
      vectors++;
      if ({mif.ack, mif.wb_cyc_o, mif.bus_err} !== 3'b101) begin
         miscompares++;
         $display("FAIL to_resp: got ack/cyc/err=%b required 101", {mif.ack, mif.wb_cyc_o, mif.bus_err});
      end
      mif.read = 1'b0;
      tick();
      vectors++;
      if (mif.bus_err !== 1'b1) begin
         miscompares++;
         $display("FAIL to_err_hold: got %b required 1", mif.bus_err);
      end
      mif.write = 1'b1; mif.data = 32'h0000_00AA;
      exp_q.push_back('{data: 32'hBAD0_BAD0, err: 1'b0});
      tick();
      vectors++;
      if ({mif.bus_err, mif.wb_cyc_o} !== 2'b01) begin
         miscompares++;
         $display("FAIL to_err_clear: got err/cyc=%b required 01", {mif.bus_err, mif.wb_cyc_o});
      end
      mif.wb_ack_i = 1'b1;
      tick();
      mif.write = 1'b0; mif.wb_ack_i = 1'b0;
      tick();
   endtask

   task automatic test_read_write_both();
      mif.read = 1'b1; mif.write = 1'b1; mif.data = 32'hA5A5_5A5A;
      exp_q.push_back('{data: 32'hBAD0_BAD0, err: 1'b0});
      tick();
      vectors++;
      if ({mif.wb_we_o, mif.wb_dat_o} !== {1'b1, 32'hA5A5_5A5A}) begin
         miscompares++;
         $display("FAIL both_we: got we=%b dat=%h required 1 a5a55a5a", mif.wb_we_o, mif.wb_dat_o);
      end
      mif.wb_ack_i = 1'b1; mif.wb_dat_i = 32'h7777_7777;
      tick();
      mif.read = 1'b0; mif.write = 1'b0; mif.wb_ack_i = 1'b0;
      tick();
   endtask

   task automatic test_ack_at_timeout();
      mif.read = 1'b1; mif.address = 32'h0000_5008;
      exp_q.push_back('{data: 32'h5EED_0004, err: 1'b0});
      tick();
      for (int i = 0; i < 4; i++) begin
         mif.wb_ack_i = (i == 3);
         mif.wb_dat_i = 32'h5EED_0004;
         tick();
      end
      vectors++;
      if ({mif.ack, mif.bus_err, mif.dataOut} !== {2'b10, 32'h5EED_0004}) begin
         miscompares++;
         $display("FAIL ack_vs_timeout: got ack=%b err=%b dataOut=%h required 1 0 5eed0004",
                  mif.ack, mif.bus_err, mif.dataOut);
      end
      mif.read = 1'b0; mif.wb_ack_i = 1'b0;
      tick();
   endtask

   task automatic test_back_to_back();
      mif.read = 1'b1; mif.address = 32'h0000_0020;
      exp_q.push_back('{data: 32'h1111_1111, err: 1'b0});
      tick();
      mif.wb_ack_i = 1'b1; mif.wb_dat_i = 32'h1111_1111;
      tick();
      mif.wb_ack_i = 1'b0;
      exp_q.push_back('{data: 32'h2222_2222, err: 1'b0});
      tick();
      vectors++;
      if ({mif.ack, mif.wb_cyc_o} !== 2'b00) begin
         miscompares++;
         $display("FAIL b2b_idle: got ack/cyc=%b required 00", {mif.ack, mif.wb_cyc_o});
      end
      tick();
      vectors++;
      if (mif.wb_cyc_o !== 1'b1) begin
         miscompares++;
         $display("FAIL b2b_second_cyc: got %b required 1", mif.wb_cyc_o);
      end
      mif.wb_ack_i = 1'b1; mif.wb_dat_i = 32'h2222_2222;
      tick();
      mif.read = 1'b0; mif.wb_ack_i = 1'b0;
      tick();
   endtask

   task automatic test_reset_mid_bus();
      mif.read = 1'b1; mif.address = 32'h0000_6000;
      tick();
      tick();
      vectors++;
      if (mif.wb_cyc_o !== 1'b1) begin
         miscompares++;
         $display("FAIL rstbus_pre: got cyc=%b required 1", mif.wb_cyc_o);
      end
      rst = 1'b1;
      tick();
      vectors++;
      if ({mif.wb_cyc_o, mif.wb_stb_o, mif.ack} !== 3'b000) begin
         miscompares++;
         $display("FAIL rstbus_drop: got cyc/stb/ack=%b required 000",
                  {mif.wb_cyc_o, mif.wb_stb_o, mif.ack});
      end
      rst = 1'b0; mif.read = 1'b0;
      mif.wb_ack_i = 1'b1; mif.wb_dat_i = 32'hDEAD_BEEF;
      for (int i = 0; i < 5; i++) begin
         tick();
         vectors++;
         if ({mif.ack, mif.wb_cyc_o, mif.dataOut} !== 34'b0) begin
            miscompares++;
            $display("FAIL rstbus_late_ack%0d: got ack=%b cyc=%b dataOut=%h required 0 0 0",
                     i, mif.ack, mif.wb_cyc_o, mif.dataOut);
         end
      end
      mif.wb_ack_i = 1'b0;
      tick();
   endtask

   initial begin
      vectors = 0; miscompares = 0;
      rst = 1'b1;
      mif.read = 1'b0; mif.write = 1'b0;
      mif.address = '0; mif.data = '0;
      mif.wb_ack_i = 1'b0; mif.wb_dat_i = '0;
      test_reset();
      test_read_zero_wait();
      test_write_wait();
      test_timeout();
      test_read_write_both();
      test_ack_at_timeout();
      test_back_to_back();
      test_reset_mid_bus();
      repeat (2) tick();
      vectors++;
      if (exp_q.size() != 0) begin
         miscompares++;
         $display("FAIL pending_responses: got %0d outstanding, required 0", exp_q.size());
      end
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
